mem_access_unit: RTL and testbench

- Parametrised load/store unit that replaces the core's fixed word-only memory path and its separate load-extend and store-truncate logic.
- Sits between the multicycle controller/datapath and the word-addressed memory/IO bus.
- Generates byte enables and can split misaligned accesses into two bus beats.
- Supports variable-latency memory through a req/ready handshake with a timeout, and sign/zero-extends load data.

---
 rtl/mem_access_unit.sv | 216 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit: byte enables, two-beat misaligned split, bus timeout,
// and sign/zero extension between the controller and a word-addressed bus.
module mem_access_unit #(
  parameter int WORD_ADDR_BITS   = 16,
  parameter bit MISALIGNED_SPLIT = 1'b1,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic                      we,
  input  logic [2:0]                funct3,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  output logic                      ready,
  output logic                      done,
  output logic [31:0]               rdata,
  output logic                      fault,
  output logic [1:0]                fault_code,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [WORD_ADDR_BITS-1:0] bus_addr,
  output logic [3:0]                bus_be,
  output logic [31:0]               bus_wdata,
  input  logic                      bus_ready,
  input  logic [31:0]               bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_cross;
  logic [1:0]  r_code;
  logic [31:0] r_lo;
  logic [31:0] r_hi;
  logic [3:0]  r_be1;
  logic [31:0] r_wd1;
  logic [CW-1:0] r_cnt;

  logic                      r_bus_req;
  logic                      r_bus_we;
  logic [WORD_ADDR_BITS-1:0] r_bus_addr;
  logic [3:0]                r_bus_be;
  logic [31:0]               r_bus_wdata;

  logic [2:0]  w_size;
  logic [3:0]  w_mask;
  logic        w_illegal;
  logic        w_cross;
  logic        w_misfault;
  logic [7:0]  w_be_sh;
  logic [63:0] w_wd_sh;
  logic        w_tmo;
  logic [63:0] w_sh64;
  logic [31:0] w_sh;
  logic [31:0] w_ext;
  logic        w_unused;

  always_comb begin
    w_size = 3'd0;
    w_mask = 4'h0;
    case (funct3[1:0])
      2'b00:   begin w_size = 3'd1; w_mask = 4'h1; end
      2'b01:   begin w_size = 3'd2; w_mask = 4'h3; end
      2'b10:   begin w_size = 3'd4; w_mask = 4'hF; end
      default: begin w_size = 3'd0; w_mask = 4'h0; end
    endcase
  end

  assign w_illegal  = (funct3[1:0] == 2'b11) | (funct3 == 3'b110)
                    | (we & funct3[2]);
  assign w_cross    = ({1'b0, addr[1:0]} + w_size) > 3'd4;
  assign w_misfault = w_cross & ~MISALIGNED_SPLIT;
  assign w_be_sh    = {4'h0, w_mask} << addr[1:0];
  assign w_wd_sh    = {32'h0, wdata} << {addr[1:0], 3'b000};

  // bus_ready in the final cycle wins over the timeout
  assign w_tmo = (TIMEOUT_CYCLES != 0)
               && (r_cnt == CW'(TIMEOUT_CYCLES)) && !bus_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (req) w_nxt = (w_illegal || w_misfault) ? RESP : BEAT0;
      end
      BEAT0: begin
        if (bus_ready) w_nxt = r_cross ? BEAT1 : RESP;
        else if (w_tmo) w_nxt = RESP;
      end
      BEAT1: begin
        if (bus_ready || w_tmo) w_nxt = RESP;
      end
      RESP:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_f3        <= 3'b000;
      r_off       <= 2'b00;
      r_cross     <= 1'b0;
      r_code      <= 2'b00;
      r_lo        <= 32'h0;
      r_hi        <= 32'h0;
      r_be1       <= 4'h0;
      r_wd1       <= 32'h0;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= 4'h0;
      r_bus_wdata <= 32'h0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req) begin
            r_we    <= we;
            r_f3    <= funct3;
            r_off   <= addr[1:0];
            r_cross <= w_cross;
            r_be1   <= w_be_sh[7:4];
            r_wd1   <= w_wd_sh[63:32];
            r_cnt   <= CW'(1);
            if (w_illegal) begin
              r_code <= 2'b10;
            end else if (w_misfault) begin
              r_code <= 2'b01;
            end else begin
              r_code      <= 2'b00;
              r_bus_req   <= 1'b1;
              r_bus_we    <= we;
              r_bus_addr  <= addr[WORD_ADDR_BITS+1:2];
              r_bus_be    <= w_be_sh[3:0];
              r_bus_wdata <= w_wd_sh[31:0];
            end
          end
        end
        BEAT0, BEAT1: begin
          if (bus_ready) begin
            if (r_state == BEAT0) r_lo <= bus_rdata;
            else                  r_hi <= bus_rdata;
            if (r_state == BEAT0 && r_cross) begin
              r_cnt       <= CW'(1);
              r_bus_addr  <= r_bus_addr + WORD_ADDR_BITS'(1);
              r_bus_be    <= r_be1;
              r_bus_wdata <= r_wd1;
            end else begin
              r_bus_req   <= 1'b0;
              r_bus_we    <= 1'b0;
              r_bus_be    <= 4'h0;
              r_bus_wdata <= 32'h0;
            end
          end else if (w_tmo) begin
            r_code      <= 2'b11;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_be    <= 4'h0;
            r_bus_wdata <= 32'h0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_sh64 = {r_hi, r_lo} >> {r_off, 3'b000};
  assign w_sh   = w_sh64[31:0];

  always_comb begin
    w_ext = w_sh;
    case (r_f3[1:0])
      2'b00:   w_ext = r_f3[2] ? {24'h0, w_sh[7:0]}
                               : {{24{w_sh[7]}}, w_sh[7:0]};
      2'b01:   w_ext = r_f3[2] ? {16'h0, w_sh[15:0]}
                               : {{16{w_sh[15]}}, w_sh[15:0]};
      default: w_ext = w_sh;
    endcase
  end

  assign ready      = (r_state == IDLE);
  assign done       = (r_state == RESP);
  assign fault      = done && (r_code != 2'b00);
  assign fault_code = done ? r_code : 2'b00;
  assign rdata      = (done && r_code == 2'b00 && !r_we) ? w_ext : 32'h0;

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

  assign w_unused = ^{addr[31:WORD_ADDR_BITS+2], w_sh64[63:32]};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: bus beats and responses are
// checked against a scoreboard filled as each access is issued.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready, done, fault;
  logic [31:0] rdata;
  logic [1:0]  fault_code;
  logic        bus_req, bus_we;
  logic [15:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        brdy = 1'b1;
  logic [31:0] brd = 32'h0;

  logic        ns_req = 1'b0;
  logic        ns_we = 1'b0;
  logic [2:0]  ns_f3 = 3'b000;
  logic [31:0] ns_addr = 32'h0;
  logic        ns_ready, ns_done, ns_fault;
  logic [31:0] ns_rdata;
  logic [1:0]  ns_code;
  logic        ns_bus_req, ns_bus_we;
  logic [15:0] ns_bus_addr;
  logic [3:0]  ns_bus_be;
  logic [31:0] ns_bus_wdata;
  logic        ns_brdy = 1'b1;
  logic [31:0] ns_brd = 32'h0;

  typedef struct packed {
    logic [15:0] a;
    logic [3:0]  be;
    logic        w;
    logic [31:0] d;
  } beat_t;

  typedef struct packed {
    logic        f;
    logic [1:0]  c;
    logic [31:0] r;
  } resp_t;

  beat_t bq[$];
  resp_t rq[$];
  logic [31:0] mem [int];

  int n_assert = 0;
  int n_fail = 0;
  int breq_cnt = 0;
  int ns_breq_cnt = 0;

  mem_access_unit #(
    .WORD_ADDR_BITS(16), .MISALIGNED_SPLIT(1'b1), .TIMEOUT_CYCLES(4)
  ) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done),
    .rdata(rdata), .fault(fault), .fault_code(fault_code),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ready(brdy),
    .bus_rdata(brd)
  );

  mem_access_unit #(
    .WORD_ADDR_BITS(16), .MISALIGNED_SPLIT(1'b0), .TIMEOUT_CYCLES(4)
  ) u_ns (
    .clk(clk), .rst(rst), .req(ns_req), .we(ns_we), .funct3(ns_f3),
    .addr(ns_addr), .wdata(32'h0), .ready(ns_ready), .done(ns_done),
    .rdata(ns_rdata), .fault(ns_fault), .fault_code(ns_code),
    .bus_req(ns_bus_req), .bus_we(ns_bus_we), .bus_addr(ns_bus_addr),
    .bus_be(ns_bus_be), .bus_wdata(ns_bus_wdata), .bus_ready(ns_brdy),
    .bus_rdata(ns_brd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int k);
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  task automatic push_beat(input logic [15:0] a, input logic [3:0] be,
                           input logic w, input logic [31:0] d);
    beat_t b;
    b.a = a; b.be = be; b.w = w; b.d = d;
    bq.push_back(b);
  endtask

  task automatic push_resp(input logic f, input logic [1:0] c,
                           input logic [31:0] r);
    resp_t x;
    x.f = f; x.c = c; x.r = r;
    rq.push_back(x);
  endtask

  task automatic start(input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    check("ready_before_req", {63'h0, ready}, 64'h1);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat0,
                           input int exp_lat);
    int lat = lat0;
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    check({tag, "_done_seen"}, {63'h0, seen}, 64'h1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  // bus model + scoreboard consumer
  initial begin
    beat_t eb;
    resp_t er;
    logic [31:0] t;
    forever begin
      @(negedge clk);
      if (bus_req) breq_cnt++;
      if (ns_bus_req) ns_breq_cnt++;
      if (bus_req && brdy) begin
        if (bq.size() == 0) begin
          check("beat_unexpected", 64'h1, 64'h0);
        end else begin
          eb = bq.pop_front();
          check("beat_addr", {48'h0, bus_addr}, {48'h0, eb.a});
          check("beat_be", {60'h0, bus_be}, {60'h0, eb.be});
          check("beat_we", {63'h0, bus_we}, {63'h0, eb.w});
          check("beat_wdata", {32'h0, bus_wdata}, {32'h0, eb.d});
          if (bus_we) begin
            t = rd(int'(bus_addr));
            for (int i = 0; i < 4; i++)
              if (bus_be[i]) t[8*i +: 8] = bus_wdata[8*i +: 8];
            mem[int'(bus_addr)] = t;
          end
        end
      end
      if (done) begin
        if (rq.size() == 0) begin
          check("resp_unexpected", 64'h1, 64'h0);
        end else begin
          er = rq.pop_front();
          check("resp_fault", {63'h0, fault}, {63'h0, er.f});
          check("resp_code", {62'h0, fault_code}, {62'h0, er.c});
          check("resp_rdata", {32'h0, rdata}, {32'h0, er.r});
        end
      end
      brd = rd(int'(bus_addr));
    end
  end

  initial begin
    int b0;
    mem[32'h41] = 32'hDEADBEEF;
    mem[32'h40] = 32'h80FFFF7F;
    mem[32'h1]  = 32'h44332211;
    mem[32'h2]  = 32'h88776655;

    repeat (2) @(negedge clk);
    check("rst_ready", {63'h0, ready}, 64'h1);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_fault", {63'h0, fault}, 64'h0);
    check("rst_code", {62'h0, fault_code}, 64'h0);
    check("rst_bus_req", {63'h0, bus_req}, 64'h0);
    check("rst_bus_we", {63'h0, bus_we}, 64'h0);
    check("rst_rdata", {32'h0, rdata}, 64'h0);
    check("rst_bus_addr", {48'h0, bus_addr}, 64'h0);
    check("rst_bus_be", {60'h0, bus_be}, 64'h0);
    check("rst_bus_wdata", {32'h0, bus_wdata}, 64'h0);
    rst = 1'b0;

    push_beat(16'h0041, 4'hF, 1'b0, 32'h0);
    push_resp(1'b0, 2'b00, 32'hDEADBEEF);
    start(1'b0, 3'b010, 32'h0000_0104, 32'h0);
    wait_done("lw", 1, 2);

    push_beat(16'h0040, 4'h8, 1'b0, 32'h0);
    push_resp(1'b0, 2'b00, 32'hFFFF_FF80);
    start(1'b0, 3'b000, 32'h103, 32'h0);
    wait_done("lb", 1, 2);

    push_beat(16'h0040, 4'h8, 1'b0, 32'h0);
    push_resp(1'b0, 2'b00, 32'h0000_0080);
    start(1'b0, 3'b100, 32'h103, 32'h0);
    wait_done("lbu", 1, 2);

    push_beat(16'h0040, 4'hC, 1'b1, 32'hABCD_0000);
    push_resp(1'b0, 2'b00, 32'h0);
    start(1'b1, 3'b001, 32'h102, 32'h1234_ABCD);
    wait_done("sh", 1, 2);

    push_beat(16'h0040, 4'h6, 1'b0, 32'h0);
    push_resp(1'b0, 2'b00, 32'hFFFF_CDFF);
    start(1'b0, 3'b001, 32'h101, 32'h0);
    wait_done("lh_off1", 1, 2);

    push_beat(16'h0040, 4'hC, 1'b0, 32'h0);
    push_resp(1'b0, 2'b00, 32'h0000_ABCD);
    start(1'b0, 3'b101, 32'h102, 32'h0);
    wait_done("lhu", 1, 2);

    push_beat(16'h0001, 4'h8, 1'b0, 32'h0);
    push_beat(16'h0002, 4'h7, 1'b0, 32'h0);
    push_resp(1'b0, 2'b00, 32'h7766_5544);
    start(1'b0, 3'b010, 32'h7, 32'h0);
    wait_done("lw_split", 1, 3);

    @(negedge clk);
    ns_req = 1'b1; ns_we = 1'b0; ns_f3 = 3'b010; ns_addr = 32'h7;
    @(posedge clk);
    #1 ns_req = 1'b0;
    @(negedge clk);
    check("ns_mis_done", {63'h0, ns_done}, 64'h1);
    check("ns_mis_fault", {63'h0, ns_fault}, 64'h1);
    check("ns_mis_code", {62'h0, ns_code}, 64'h1);
    check("ns_mis_rdata", {32'h0, ns_rdata}, 64'h0);

    @(negedge clk);
    ns_req = 1'b1; ns_we = 1'b1; ns_f3 = 3'b101; ns_addr = 32'h3;
    @(posedge clk);
    #1 ns_req = 1'b0;
    @(negedge clk);
    check("ns_prio_done", {63'h0, ns_done}, 64'h1);
    check("ns_prio_code", {62'h0, ns_code}, 64'h2);

    push_beat(16'hFFFF, 4'hC, 1'b1, 32'hC3D4_0000);
    push_beat(16'h0000, 4'h3, 1'b1, 32'h0000_A1B2);
    push_resp(1'b0, 2'b00, 32'h0);
    start(1'b1, 3'b010, 32'h0003_FFFE, 32'hA1B2_C3D4);
    wait_done("sw_wrap", 1, 3);

    push_beat(16'hFFFF, 4'hC, 1'b0, 32'h0);
    push_beat(16'h0000, 4'h3, 1'b0, 32'h0);
    push_resp(1'b0, 2'b00, 32'hA1B2_C3D4);
    start(1'b0, 3'b010, 32'h0003_FFFE, 32'h0);
    wait_done("lw_wrap", 1, 3);

    push_resp(1'b1, 2'b10, 32'h0);
    start(1'b0, 3'b011, 32'h104, 32'h0);
    wait_done("ill_f3", 1, 1);

    push_resp(1'b1, 2'b10, 32'h0);
    start(1'b1, 3'b100, 32'h104, 32'hFFFF_FFFF);
    wait_done("ill_store", 1, 1);

    brdy = 1'b0;
    b0 = breq_cnt;
    push_resp(1'b1, 2'b11, 32'h0);
    start(1'b0, 3'b010, 32'h104, 32'h0);
    wait_done("tmo", 1, 5);
    check("tmo_breq_cycles", 64'(breq_cnt - b0), 64'd4);

    push_beat(16'h0041, 4'hF, 1'b0, 32'h0);
    push_resp(1'b0, 2'b00, 32'hDEADBEEF);
    start(1'b0, 3'b010, 32'h104, 32'h0);
    repeat (3) @(posedge clk);
    #1 brdy = 1'b1;
    wait_done("tmo_rescue", 4, 5);

    push_beat(16'h0001, 4'h8, 1'b0, 32'h0);
    start(1'b0, 3'b010, 32'h7, 32'h0);
    @(posedge clk);
    #1 brdy = 1'b0;
    @(negedge clk);
    check("b1_bus_req", {63'h0, bus_req}, 64'h1);
    check("b1_bus_addr", {48'h0, bus_addr}, 64'h2);
    check("b1_bus_be", {60'h0, bus_be}, 64'h7);
    #2 rst = 1'b1;
    #1;
    check("arst_bus_req", {63'h0, bus_req}, 64'h0);
    check("arst_done", {63'h0, done}, 64'h0);
    check("arst_ready", {63'h0, ready}, 64'h1);
    @(negedge clk);
    rst = 1'b0;
    brdy = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {63'h0, ready}, 64'h1);

    push_beat(16'h0041, 4'hF, 1'b0, 32'h0);
    push_resp(1'b0, 2'b00, 32'hDEADBEEF);
    start(1'b0, 3'b010, 32'h104, 32'h0);
    wait_done("lw_after_rst", 1, 2);

    @(negedge clk);
    check("ns_never_bus_req", 64'(ns_breq_cnt), 64'd0);
    check("beats_drained", 64'(bq.size()), 64'd0);
    check("resps_drained", 64'(rq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
